// File: rtl/seven_seg_scan_controller.sv
// Multiplexed four-digit seven-segment scanner with dead-time between digits.
// A single-entry pending buffer is committed only at frame boundaries.
module seven_seg_scan_controller #(
  parameter int DRIVE_CYCLES = 50000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value_in,
  input  logic        lzb,
  output logic        ready,
  output logic [3:0]  digit_sel,
  output logic [6:0]  seg_code,
  output logic        frame_done
);

  localparam int MAXC = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DRIVE_LAST = CW'(DRIVE_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic {DRIVE, BLANK} state_t;

  // Position registers describe the slot cycle that the next edge will emit.
  state_t          state_reg;
  logic [1:0]      idx_reg;
  logic [CW-1:0]   cnt_reg;
  logic            started_reg;
  logic [15:0]     disp_reg;
  logic [15:0]     pend_reg;
  logic            pend_v_reg;

  logic            frame_start;
  logic            commit;
  logic            accept;
  logic            pend_v_next;
  logic [15:0]     disp_next;
  logic [6:0]      dig_seg [4];

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    frame_start = (state_reg == DRIVE) && (idx_reg == 2'd0) && (cnt_reg == '0);
    commit      = frame_start && pend_v_reg;
    accept      = load && ready;
    disp_next   = commit ? pend_reg : disp_reg;
    pend_v_next = pend_v_reg;
    if (commit) pend_v_next = 1'b0;
    if (accept) pend_v_next = 1'b1;
  end

  // The emitted digit always decodes the value being shown this frame,
  // including the value that is committed on this very edge.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      if (gi == 0) begin : g_lsd
        assign dig_seg[gi] = decode(disp_next[3:0]);
      end else begin : g_upper
        logic upper_zero;
        assign upper_zero  = (disp_next[15:4*gi] == '0);
        assign dig_seg[gi] = (lzb && upper_zero) ? 7'b1111111
                                                 : decode(disp_next[4*gi +: 4]);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= DRIVE;
      idx_reg     <= 2'd0;
      cnt_reg     <= '0;
      started_reg <= 1'b0;
      disp_reg    <= 16'h0000;
      pend_v_reg  <= 1'b0;
      ready       <= 1'b1;
      digit_sel   <= 4'b1111;
      seg_code    <= 7'b1111111;
      frame_done  <= 1'b0;
    end else begin
      if (accept) pend_reg <= value_in;
      pend_v_reg  <= pend_v_next;
      ready       <= ~pend_v_next;
      disp_reg    <= disp_next;
      started_reg <= 1'b1;
      frame_done  <= frame_start && started_reg;

      if (state_reg == DRIVE) begin
        digit_sel <= ~(4'b0001 << idx_reg);
        seg_code  <= dig_seg[idx_reg];
        if (cnt_reg == DRIVE_LAST) begin
          state_reg <= BLANK;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        digit_sel <= 4'b1111;
        seg_code  <= 7'b1111111;
        if (cnt_reg == BLANK_LAST) begin
          state_reg <= DRIVE;
          cnt_reg   <= '0;
          idx_reg   <= idx_reg + 2'd1;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Directed bench for the scan controller with DRIVE_CYCLES=4, BLANK_CYCLES=2 (24-cycle frame).
module tb_seven_seg_scan_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value_in;
  logic        lzb;
  logic        ready;
  logic [3:0]  digit_sel;
  logic [6:0]  seg_code;
  logic        frame_done;

  int tests_run = 0;
  int tests_failed = 0;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seven_seg_scan_controller #(
    .DRIVE_CYCLES(4),
    .BLANK_CYCLES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .value_in   (value_in),
    .lzb        (lzb),
    .ready      (ready),
    .digit_sel  (digit_sel),
    .seg_code   (seg_code),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int cyc, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s cycle %0d: got %b expected %b", tag, cyc, got, exp);
    end
  endtask

  initial begin
    int          origin, p, f, w, slot, inslot;
    logic [15:0] val;
    logic [15:0] shifted;
    logic [3:0]  nib;
    logic [3:0]  exp_sel;
    logic [6:0]  exp_seg;
    logic        exp_ready, exp_fd, blank_mode;

    reset = 1'b1; load = 1'b0; value_in = 16'h0; lzb = 1'b0;
    repeat (3) @(negedge clk);
    // cycle 0: outputs still hold reset values
    check("rst_sel",   0, {12'h0, digit_sel}, 16'h000F);
    check("rst_seg",   0, {9'h0, seg_code},   16'h007F);
    check("rst_ready", 0, {15'h0, ready},     16'h0001);
    check("rst_fd",    0, {15'h0, frame_done}, 16'h0000);
    $display("[TB] cycle 0 reset released");
    reset = 1'b0;

    for (int cyc = 1; cyc <= 186; cyc++) begin
      @(negedge clk);
      if (cyc == 135) begin
        check("midrst_sel",   cyc, {12'h0, digit_sel}, 16'h000F);
        check("midrst_seg",   cyc, {9'h0, seg_code},   16'h007F);
        check("midrst_ready", cyc, {15'h0, ready},     16'h0001);
        check("midrst_fd",    cyc, {15'h0, frame_done}, 16'h0000);
      end else begin
        origin = (cyc >= 136) ? 136 : 1;
        p = cyc - origin;
        f = p / 24;
        w = p % 24;
        slot = w / 6;
        inslot = w % 6;
        if (origin == 136) val = 16'h0000;
        else begin
          case (f)
            0:       val = 16'h0000;
            1, 2:    val = 16'h0A3F;
            3, 4:    val = 16'h0070;
            default: val = 16'h1234;
          endcase
        end
        blank_mode = (cyc >= 73) && (cyc <= 96);
        shifted = val >> (4 * slot);
        nib = shifted[3:0];
        if (inslot < 4) begin
          exp_sel = ~(4'b0001 << slot);
          exp_seg = (blank_mode && slot > 0 && shifted == 16'h0) ? 7'b1111111 : seg_tab[nib];
        end else begin
          exp_sel = 4'b1111;
          exp_seg = 7'b1111111;
        end
        if (cyc <= 3)        exp_ready = 1'b1;
        else if (cyc <= 24)  exp_ready = 1'b0;
        else if (cyc <= 48)  exp_ready = 1'b1;
        else if (cyc <= 72)  exp_ready = 1'b0;
        else if (cyc <= 100) exp_ready = 1'b1;
        else if (cyc <= 120) exp_ready = 1'b0;
        else if (cyc <= 125) exp_ready = 1'b1;
        else if (cyc <= 134) exp_ready = 1'b0;
        else                 exp_ready = 1'b1;
        exp_fd = (w == 0) && (f > 0);
        check("digit_sel",  cyc, {12'h0, digit_sel},  {12'h0, exp_sel});
        check("seg_code",   cyc, {9'h0, seg_code},    {9'h0, exp_seg});
        check("ready",      cyc, {15'h0, ready},      {15'h0, exp_ready});
        check("frame_done", cyc, {15'h0, frame_done}, {15'h0, exp_fd});
      end
      $display("[TB] cycle %0d sel=%b seg=%b ready=%b fd=%b", cyc, digit_sel, seg_code, ready, frame_done);

      load  = 1'b0;
      reset = (cyc == 134);
      lzb   = (cyc >= 72) && (cyc <= 95);
      case (cyc)
        3:   begin load = 1'b1; value_in = 16'h0A3F; end
        10:  begin load = 1'b1; value_in = 16'h1111; end
        48:  begin load = 1'b1; value_in = 16'h0070; end
        100: begin load = 1'b1; value_in = 16'h1234; end
        125: begin load = 1'b1; value_in = 16'h5678; end
        134: begin load = 1'b1; value_in = 16'h9999; end
        default: ;
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_controller.md
SEVEN_SEG_SCAN_CONTROLLER -- requirements
Module: seven_seg_scan_controller

Interface
REQ-001 Parameter DRIVE_CYCLES, default 50000: cycles each digit is driven per scan slot; legal values >= 1.
REQ-002 Parameter BLANK_CYCLES, default 8: dead-time cycles after each drive slot, all digits off; legal values >= 1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 load  input  1  request to display value_in; accepted only in a cycle with ready=1.
REQ-006 value_in  input  16  four hex nibbles; [3:0] = digit 0 (rightmost) ... [15:12] = digit 3.
REQ-007 lzb  input  1  leading-zero blanking enable; sampled every cycle.
REQ-008 ready  output  1  high = pending slot free, load will be accepted.
REQ-009 digit_sel  output  4  active-low one-hot digit enable; bit k = digit k.
REQ-010 seg_code  output  7  active-low segments; bit0=a ... bit6=g.
REQ-011 frame_done  output  1  one-cycle pulse at end of each full 4-digit scan.

Function
REQ-012 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-013 Internal registers: disp (16b, shown value), pend (16b), pend_v (1b), idx (2b), cycle counter, state in {DRIVE, BLANK}.
REQ-014 Handshake: load=1 and ready=1 at an edge SHALL set pend<=value_in, pend_v<=1; ready SHALL be 0 from the next cycle.
REQ-015 load while ready=0 SHALL be ignored; no queuing, pend unchanged.
REQ-016 DRIVE(idx): digit_sel = ~(4'b0001<<idx); seg_code = decode(disp nibble idx); held exactly DRIVE_CYCLES cycles, then BLANK.
REQ-017 BLANK: digit_sel=4'b1111, seg_code=7'b1111111; held exactly BLANK_CYCLES cycles, then DRIVE(idx+1 mod 4).
REQ-018 Frame = 4*(DRIVE_CYCLES+BLANK_CYCLES) cycles; order digit 0,1,2,3, wrap to 0.
REQ-019 frame_done SHALL be 1 exactly in the first DRIVE(0) cycle of every frame after the first post-reset frame.
REQ-020 Commit: at the edge leaving the last BLANK cycle after digit 3, if pend_v=1 then disp<=pend, pend_v<=0, ready=1 next cycle.
REQ-021 A load accepted on that same commit edge SHALL NOT be committed then; it is committed at the following frame boundary.
REQ-022 disp SHALL never change mid-frame (no tearing).
REQ-023 decode, active-low gfedcba: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 B=0000011 C=1000110 D=0100001 E=0000110 F=0001110.
REQ-024 lzb=1: digit k>0 SHALL show 7'b1111111 (digit_sel still active) when disp nibbles k..3 are all zero; digit 0 never blanked.
REQ-025 lzb=0: all four digits decoded normally, zeros shown.

Reset
REQ-026 reset=1 at an edge SHALL, regardless of state: digit_sel=4'b1111, seg_code=7'b1111111, ready=1, frame_done=0, disp=0, pend_v=0, idx=0, counter=0.
REQ-027 First cycle after reset deasserts SHALL be DRIVE(0) cycle 1; a pending value at reset is discarded.
REQ-028 load is ignored in any cycle with reset=1.

Verification (DRIVE_CYCLES=4, BLANK_CYCLES=2, frame=24 cycles)
REQ-029 Reset release, no load, lzb=0 -> digit_sel 1110 x4, 1111 x2, 1101 x4, 1111 x2, 1011..., 0111...; seg_code 1000000 when driven; frame_done at cycle 25 only.
REQ-030 load value_in=16'h0A3F at cycle 3 -> ready=0 cycles 4..24; frame 2 shows F=0001110, 3=0110000, A=0001000, 0=1000000; ready=1 at cycle 25.
REQ-031 Second load at cycle 10 while ready=0, value 16'h1111 -> ignored; frame 2 still shows 0A3F.
REQ-032 disp=16'h0070, lzb=1 -> digits 3,2 seg 1111111, digit 1 1111000, digit 0 1000000; lzb=0 -> digits 3,2 show 1000000.
REQ-033 load exactly on commit edge (cycle 24) -> frame 2 shows old disp, frame 3 shows new value.
REQ-034 reset asserted mid DRIVE(2) with pend_v=1 -> next cycle all outputs at reset values; after release digit 0 shows 0, pending value never appears.
